// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: bus widths,
// parity-type encodings, receiver FSM state encoding and a 3-input majority
// helper used by the oversampling logic.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PRESCALE_W = 6;
  localparam int DATA_W     = 8;

  // PAR_TYP encodings, shared with the transmitter
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling engine. Counts CLK cycles inside a bit period
// (edge_cnt 0..P-1), takes three samples around the bit centre and resolves
// them by majority vote.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_enable        : count while high; edge_cnt is held at 0 while low
//   i_rx            : serial line
//   i_prescale      : P, CLK cycles per bit (even, 4..32)
//   o_sampled_bit   : resolved bit value, valid from o_sample_done onward
//   o_sample_done   : strobe at edge_cnt = P/2+1 (vote resolved this cycle)
//   o_bit_done      : strobe at edge_cnt = P-1 (last cycle of the bit)
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_sampled_bit,
  output logic                  o_sample_done,
  output logic                  o_bit_done
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_bit;

  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_mid_lo;
  logic [PRESCALE_W-1:0] w_mid_hi;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_vote;

  assign w_half   = i_prescale >> 1;
  assign w_mid_lo = w_half - PRESCALE_W'(1);
  assign w_mid_hi = w_half + PRESCALE_W'(1);
  assign w_last   = i_prescale - PRESCALE_W'(1);

  // Third sample is the live line value, so the vote resolves in the same
  // cycle as the last sample.
  assign w_vote        = majority3(r_s0, r_s1, i_rx);
  assign o_sample_done = i_enable && (r_edge_cnt == w_mid_hi);
  assign o_bit_done    = i_enable && (r_edge_cnt == w_last);
  // At P=4 the vote and the end of the bit coincide, so the fresh vote is
  // forwarded combinationally rather than waiting for r_bit.
  assign o_sampled_bit = o_sample_done ? w_vote : r_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_bit      <= 1'b0;
    end else if (!i_enable) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= o_bit_done ? '0 : r_edge_cnt + PRESCALE_W'(1);
      if (r_edge_cnt == w_mid_lo) r_s0 <= i_rx;
      if (r_edge_cnt == w_half)   r_s1 <= i_rx;
      if (o_sample_done)          r_bit <= w_vote;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, 8 data bits LSB first, optional parity, 1 stop
// bit, oversampled by Prescale CLK cycles per bit.
// Ports:
//   CLK          : oversampling clock (Prescale x baud)
//   RST          : asynchronous active-low reset
//   RX_IN        : serial line, idle high
//   PAR_EN       : frame carries a parity bit
//   PAR_TYP      : 0 even, 1 odd
//   Prescale     : CLK cycles per bit (even, 4..32)
//   P_DATA       : last error-free byte, held between frames
//   data_valid   : 1-cycle pulse, P_DATA updated
//   Parity_Error : 1-cycle pulse, parity mismatch
//   Stop_Error   : 1-cycle pulse, stop bit sampled low
// Handshake: data_valid is a one-cycle strobe with no back-pressure; P_DATA is
// stable from the strobe until the next error-free frame.
// FSM state is visible as r_state (rx_state_t) for debug.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [5:0]        Prescale,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              Parity_Error,
  output logic              Stop_Error
);

  rx_state_t             r_state;
  logic [2:0]            r_bit_cnt;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_par_fail;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [PRESCALE_W-1:0] r_prescale;

  logic w_active;
  logic w_sampled_bit;
  logic w_sample_done;
  logic w_bit_done;
  logic w_exp_par;

  // The detecting edge itself is frame cycle 0, so the sampler counts it.
  assign w_active  = (r_state != ST_IDLE) || !RX_IN;
  assign w_exp_par = (r_par_typ == PAR_EVEN) ? ^r_shift : ~^r_shift;

  uart_rx_sampler u_sampler (
    .i_clk         (CLK),
    .i_rst_n       (RST),
    .i_enable      (w_active),
    .i_rx          (RX_IN),
    .i_prescale    (r_prescale),
    .o_sampled_bit (w_sampled_bit),
    .o_sample_done (w_sample_done),
    .o_bit_done    (w_bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_fail   <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_prescale   <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!RX_IN) begin
            // Configuration is frozen for the whole frame from here.
            r_state    <= ST_START;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= Prescale;
            r_bit_cnt  <= '0;
            r_par_fail <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that votes high was a glitch; drop it silently.
          if (w_bit_done) r_state <= w_sampled_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift[r_bit_cnt] <= w_sampled_bit;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_par_fail <= (w_sampled_bit != w_exp_par);
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (w_sampled_bit && !r_par_fail) begin
              P_DATA     <= r_shift;
              data_valid <= 1'b1;
            end else begin
              Parity_Error <= r_par_fail;
              Stop_Error   <= !w_sampled_bit;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Vote timing is only consumed through o_sampled_bit at bit end.
  logic w_unused;
  assign w_unused = w_sample_done;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed frames drive RX_IN; each frame pushes its expected response
// (output edge index, flags, P_DATA) into exp_q, and a monitor pops and
// compares whenever the DUT raises any output strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W = 43;  // {edge_idx[31:0], perr, serr, valid, data[7:0]}

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_item;
  logic [7:0]   last_good = 8'h00;

  uart_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, input int p);
    repeat (p) begin
      @(negedge CLK);
      RX_IN = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // flags = {perr, serr, valid}
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_typ,
                            input logic par_bit, input logic stop_bit, input int p,
                            input logic [2:0] flags);
    int n;
    int start_idx;
    logic [7:0] exp_data;
    n = par_en ? 11 : 10;
    @(negedge CLK);
    PAR_EN    = par_en;
    PAR_TYP   = par_typ;
    Prescale  = 6'(p);
    RX_IN     = 1'b0;
    start_idx = cyc;  // index of the posedge that detects the start bit
    exp_data  = flags[0] ? d : last_good;
    if (flags[0]) last_good = d;
    exp_q.push_back({32'(start_idx + n * p - 1), flags, exp_data});
    // Scramble configuration mid-frame; the receiver must ignore it.
    @(negedge CLK);
    PAR_EN   = ~par_en;
    PAR_TYP  = ~par_typ;
    Prescale = 6'd4;
    repeat (p - 2) @(negedge CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_en) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (data_valid || Parity_Error || Stop_Error) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got v=%0b pe=%0b se=%0b data=%0h expected none",
                 data_valid, Parity_Error, Stop_Error, P_DATA);
      end else begin
        mon_item = exp_q.pop_front();
        check("event_cycle", 32'(cyc - 1), mon_item[42:11]);
        check("event_flags", {29'd0, Parity_Error, Stop_Error, data_valid}, {29'd0, mon_item[10:8]});
        check("p_data", {24'd0, P_DATA}, {24'd0, mon_item[7:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g_start;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_p_data", {24'd0, P_DATA}, 32'h00);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_perr", {31'd0, Parity_Error}, 32'd0);
    check("rst_serr", {31'd0, Stop_Error}, 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(negedge CLK);
    RST = 1'b1;
    idle(4);

    // No parity, P=8: valid at frame cycle 79
    send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, 3'b001);
    idle(5);
    // Even parity, P=16: good parity, then bad parity
    send_frame(8'h48, 1'b1, PAR_EVEN, 1'b0, 1'b1, 16, 3'b001);
    idle(5);
    send_frame(8'h48, 1'b1, PAR_EVEN, 1'b1, 1'b1, 16, 3'b100);
    idle(5);
    // Odd parity, P=32: good frame, then stop bit 0 (parity correct)
    send_frame(8'h48, 1'b1, PAR_ODD, 1'b1, 1'b1, 32, 3'b001);
    idle(5);
    send_frame(8'hFF, 1'b1, PAR_ODD, 1'b1, 1'b0, 32, 3'b010);
    idle(5);

    // Glitch, P=8: line low for two cycles only
    @(negedge CLK);
    PAR_EN   = 1'b0;
    Prescale = 6'd8;
    RX_IN    = 1'b0;
    g_start  = cyc;
    @(negedge CLK);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("glitch_cycle_ref", 32'(cyc), 32'(g_start + 7));
    check("glitch_state_c6", 32'(dut.r_state), 32'(ST_START));
    @(negedge CLK);
    check("glitch_state_c7", 32'(dut.r_state), 32'(ST_IDLE));
    idle(5);
    send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, 3'b001);
    idle(5);

    // Back-to-back, P=8, zero idle gap: pulses 80 cycles apart
    send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, 3'b001);
    send_frame(8'hFF, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, 3'b001);
    idle(5);

    // Reset during data bit 4 of 0x5A
    @(negedge CLK);
    PAR_EN   = 1'b0;
    Prescale = 6'd8;
    RX_IN    = 1'b0;
    repeat (7) @(negedge CLK);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0, 8);  // 0x5A low nibble = 1010
    repeat (3) begin
      @(negedge CLK);
      RX_IN = 1'b1;  // bit 4 of 0x5A
    end
    check("mid_state", 32'(dut.r_state), 32'(ST_DATA));
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_p_data", {24'd0, P_DATA}, 32'h00);
    check("mid_rst_flags", {29'd0, Parity_Error, Stop_Error, data_valid}, 32'd0);
    check("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    last_good = 8'h00;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(6);
    send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, 3'b001);

    // Drain outstanding expectations, then watch for stray pulses.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
